// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: word width, NOP encoding,
// default program size and the fetch state encoding.
package fetch_stage_pkg;
    localparam int WORD_W            = 32;
    localparam int DEFAULT_ROM_DEPTH = 82;
    localparam logic [WORD_W-1:0] NOP_INS = 32'h00000000;

    typedef enum logic {RUN, HALT} fetchState_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ROM address/data, hazard and redirect controls, IF/ID outputs
// and statistics. master = fetch stage, slave = surrounding pipeline / ROM.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [WORD_W-1:0] PcOut;
    logic [WORD_W-1:0] InsIn;
    logic              Stall;
    logic              Redirect;
    logic [WORD_W-1:0] TargetIn;
    logic [WORD_W-1:0] IfIdIns;
    logic [WORD_W-1:0] IfIdPc;
    logic              IfIdValid;
    logic              Done;
    logic [WORD_W-1:0] FetchCount;
    logic [WORD_W-1:0] StallCount;

    modport master (
        output PcOut, IfIdIns, IfIdPc, IfIdValid, Done, FetchCount, StallCount,
        input  InsIn, Stall, Redirect, TargetIn
    );

    modport slave (
        input  PcOut, IfIdIns, IfIdPc, IfIdValid, Done, FetchCount, StallCount,
        output InsIn, Stall, Redirect, TargetIn
    );
endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Enable-driven up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en && (count != '1))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, IF/ID register and
// fetch/stall statistics. RUN/HALT is derived from the PC every cycle.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ROM_DEPTH = DEFAULT_ROM_DEPTH,
    parameter logic [WORD_W-1:0] RESET_PC  = '0
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master fif
);
    localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(ROM_DEPTH);

    fetchState_e       state;
    logic [WORD_W-1:0] pc, pcNext, pcInc;
    logic [WORD_W-1:0] ifIdIns, ifIdInsNext;
    logic [WORD_W-1:0] ifIdPc, ifIdPcNext;
    logic              ifIdValid, ifIdValidNext;
    logic              fetchEn, stallEn;

    assign pcInc = pc + 1'b1;

    // Redirect beats Stall; a redirect leaves both counters untouched.
    always_comb begin
        state         = (pc >= DEPTH_W) ? HALT : RUN;
        pcNext        = pc;
        ifIdInsNext   = ifIdIns;
        ifIdPcNext    = ifIdPc;
        ifIdValidNext = ifIdValid;
        fetchEn       = 1'b0;
        stallEn       = 1'b0;
        if (fif.Redirect) begin
            pcNext        = fif.TargetIn;
            ifIdInsNext   = NOP_INS;
            ifIdPcNext    = '0;
            ifIdValidNext = 1'b0;
        end else if (fif.Stall) begin
            stallEn = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    ifIdInsNext   = fif.InsIn;
                    ifIdPcNext    = pc;
                    ifIdValidNext = 1'b1;
                    pcNext        = (pcInc > DEPTH_W) ? DEPTH_W : pcInc;
                    fetchEn       = 1'b1;
                end
                HALT: begin
                    ifIdInsNext   = NOP_INS;
                    ifIdValidNext = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            ifIdIns   <= NOP_INS;
            ifIdPc    <= '0;
            ifIdValid <= 1'b0;
        end else begin
            pc        <= pcNext;
            ifIdIns   <= ifIdInsNext;
            ifIdPc    <= ifIdPcNext;
            ifIdValid <= ifIdValidNext;
        end
    end

    sat_counter #(.W(WORD_W)) uFetchCnt (
        .clk(clk), .rst(rst), .en(fetchEn), .count(fif.FetchCount)
    );

    sat_counter #(.W(WORD_W)) uStallCnt (
        .clk(clk), .rst(rst), .en(stallEn), .count(fif.StallCount)
    );

    assign fif.PcOut     = pc;
    assign fif.Done      = (state == HALT);
    assign fif.IfIdIns   = ifIdIns;
    assign fif.IfIdPc    = ifIdPc;
    assign fif.IfIdValid = ifIdValid;
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage: a behavioural model queues the
// expected post-edge state, a monitor pops and compares after every edge.
module tb_fetch_stage;
    localparam int DEPTH = 82;
    localparam logic [31:0] MAXC = 32'hFFFFFFFF;

    typedef struct {
        logic [31:0] pc, ins, ifPc, fetch, stall;
        logic        valid, chkPc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    fetch_stage_if fif ();

    fetch_stage #(.ROM_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .fif(fif)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [0:DEPTH-1];
    // Out-of-range reads return garbage so a missing NOP substitution shows up.
    always_comb fif.InsIn = (fif.PcOut < DEPTH) ? rom[fif.PcOut[6:0]] : 32'hDEADBEEF;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] mPc, mIns, mIfPc, mFetch, mStall;
    logic mValid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = 0; mIns = 0; mIfPc = 0; mValid = 0; mFetch = 0; mStall = 0;
    endtask

    // Apply inputs for one edge, predict the result and queue it.
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        exp_t e;
        logic chkPc;
        fif.Stall = s; fif.Redirect = r; fif.TargetIn = t;
        chkPc = 1'b0;
        if (r) begin
            mPc = t; mIns = 0; mIfPc = 0; mValid = 0; chkPc = 1'b1;
        end else if (s) begin
            if (mStall != MAXC) mStall++;
            chkPc = mValid;
        end else if (mPc < DEPTH) begin
            mIns = rom[mPc[6:0]]; mIfPc = mPc; mValid = 1; mPc = mPc + 1;
            if (mFetch != MAXC) mFetch++;
            chkPc = 1'b1;
        end else begin
            mIns = 0; mValid = 0;
        end
        e.pc = mPc; e.ins = mIns; e.ifPc = mIfPc; e.fetch = mFetch;
        e.stall = mStall; e.valid = mValid; e.chkPc = chkPc;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            #2;
            e = q.pop_front();
            chk("PcOut", fif.PcOut, e.pc);
            chk("Done", {31'd0, fif.Done}, {31'd0, e.pc >= DEPTH});
            chk("IfIdIns", fif.IfIdIns, e.ins);
            chk("IfIdValid", {31'd0, fif.IfIdValid}, {31'd0, e.valid});
            if (e.chkPc) chk("IfIdPc", fif.IfIdPc, e.ifPc);
            chk("FetchCount", fif.FetchCount, e.fetch);
            chk("StallCount", fif.StallCount, e.stall);
        end
    end

    task automatic chkReset(input string tag);
        chk({tag, "_PcOut"}, fif.PcOut, 32'd0);
        chk({tag, "_IfIdIns"}, fif.IfIdIns, 32'd0);
        chk({tag, "_IfIdPc"}, fif.IfIdPc, 32'd0);
        chk({tag, "_IfIdValid"}, {31'd0, fif.IfIdValid}, 32'd0);
        chk({tag, "_Done"}, {31'd0, fif.Done}, 32'd0);
        chk({tag, "_FetchCount"}, fif.FetchCount, 32'd0);
        chk({tag, "_StallCount"}, fif.StallCount, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
        rom[0] = 32'h0000008e; rom[1] = 32'h0000010e;
        rom[2] = 32'h0; rom[3] = 32'h0; rom[4] = 32'h0;
        rst = 1'b1; fif.Stall = 1'b0; fif.Redirect = 1'b0; fif.TargetIn = 32'd0;
        modelReset();
        @(posedge clk); #3;
        rst = 1'b0; #1;
        chkReset("rst");

        // Free-run 5
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0);

        // Async reset mid-cycle: outputs clear before any edge
        #3 rst = 1'b1; #1;
        chkReset("async");
        modelReset();
        @(posedge clk); #3 rst = 1'b0;

        // Stall 3 cycles at PC=2, then resume
        step(1'b0, 1'b0, 32'd0); step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);

        // Redirect with concurrent stall
        step(1'b1, 1'b1, 32'd20);
        step(1'b0, 1'b0, 32'd0); step(1'b0, 1'b0, 32'd0);

        // Run off the end, idle in HALT, stall in HALT, come back
        step(1'b0, 1'b1, 32'd75);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'd63);
        step(1'b0, 1'b0, 32'd0); step(1'b0, 1'b0, 32'd0);

        // Out-of-range redirect halts immediately
        step(1'b0, 1'b1, 32'd100);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic s, r;
            logic [31:0] t;
            r = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 90));
            step(s, r, t);
        end

        #5;
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
